model_convolution_shift: RTL and testbench

Circular-convolution (location-based shift) stage of the NTM addressing path. It computes w~(j) = Σ_k w_g(k)·s((j−k) mod n) for j = 0..n−1, where w_g is the interpolated weighting, s is the shift weighting and n is the vector size. It buffers both input vectors, runs a sequential MAC, and streams the shifted weighting out element by element. It sits upstream of sharpening/model_reading, and its W_OUT stream drives their W_IN.

---
 rtl/model_ntm_pkg.sv | 19 +
 rtl/model_fixed_multiplier.sv | 17 +
 rtl/model_convolution_shift.sv | 172 +++++++++++++++++
 tb/tb_model_convolution_shift.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/model_ntm_pkg.sv
// Shared definitions for the NTM addressing-path models: FSM encoding and
// fixed-point format constants.
package model_ntm_pkg;

    localparam int CONTROL_SIZE      = 4;
    localparam int DATA_SIZE_DEF     = 64;
    localparam int FRACTION_SIZE_DEF = 32;

    localparam logic [DATA_SIZE_DEF-1:0] FIXED_ONE = 64'h1 << FRACTION_SIZE_DEF;

    typedef enum logic [CONTROL_SIZE-1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_COMPUTE,
        ST_EMIT,
        ST_DONE
    } state_t;

endpackage

// File: rtl/model_fixed_multiplier.sv
// Combinational signed fixed-point multiply: full-width product, arithmetic
// shift by the fraction width, low DATA_SIZE bits kept (wraps, no saturation).
module model_fixed_multiplier #(
    parameter int DATA_SIZE     = 64,
    parameter int FRACTION_SIZE = 32
) (
    input  logic [DATA_SIZE-1:0] a_i,
    input  logic [DATA_SIZE-1:0] b_i,
    output logic [DATA_SIZE-1:0] p_o
);

    logic signed [2*DATA_SIZE-1:0] full;

    assign full = $signed(a_i) * $signed(b_i);
    assign p_o  = DATA_SIZE'(full >>> FRACTION_SIZE);

endmodule

// File: rtl/model_convolution_shift.sv
// Circular convolution of the gated weighting with the shift weighting:
// buffers both vectors, runs one MAC per cycle and streams each result out.
module model_convolution_shift
    import model_ntm_pkg::*;
#(
    parameter int DATA_SIZE     = DATA_SIZE_DEF,
    parameter int FRACTION_SIZE = FRACTION_SIZE_DEF,
    parameter int N             = 64
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic                 START,
    output logic                 READY,
    input  logic                 W_IN_ENABLE,
    input  logic                 S_IN_ENABLE,
    output logic                 W_OUT_ENABLE,
    input  logic [DATA_SIZE-1:0] SIZE_N_IN,
    input  logic [DATA_SIZE-1:0] W_IN,
    input  logic [DATA_SIZE-1:0] S_IN,
    output logic [DATA_SIZE-1:0] W_OUT
);

    localparam int IW = $clog2(N + 1);
    localparam int AW = $clog2(N);
    localparam logic [IW-1:0] ONE_I = IW'(1);

    state_t state_q, state_d;
    logic [IW-1:0] n_q, n_d, wi_q, wi_d, si_q, si_d;
    logic [IW-1:0] j_q, j_d, k_q, k_d, p_q, p_d;
    logic [DATA_SIZE-1:0] acc_q, acc_d, wout_q, wout_d;
    logic ready_q, ready_d, woe_q, woe_d;

    logic [DATA_SIZE-1:0] w_buf [N];
    logic [DATA_SIZE-1:0] s_buf [N];

    logic [IW-1:0] size_clamp, n_m1, wi_nx, si_nx;
    logic [DATA_SIZE-1:0] prod, mac_sum;
    logic w_we, s_we, load_done, k_last, j_last;

    assign size_clamp = (SIZE_N_IN > DATA_SIZE'(N)) ? IW'(N) : SIZE_N_IN[IW-1:0];
    assign n_m1       = n_q - ONE_I;
    assign w_we       = (state_q == ST_LOAD) && W_IN_ENABLE && (wi_q < n_q);
    assign s_we       = (state_q == ST_LOAD) && S_IN_ENABLE && (si_q < n_q);
    assign wi_nx      = wi_q + IW'(w_we);
    assign si_nx      = si_q + IW'(s_we);
    assign load_done  = (state_q == ST_LOAD) && (wi_nx == n_q) && (si_nx == n_q);
    assign k_last     = (k_q == n_m1);
    assign j_last     = (j_q == n_m1);
    assign mac_sum    = acc_q + prod;

    model_fixed_multiplier #(
        .DATA_SIZE    (DATA_SIZE),
        .FRACTION_SIZE(FRACTION_SIZE)
    ) u_mul (
        .a_i(w_buf[k_q[AW-1:0]]),
        .b_i(s_buf[p_q[AW-1:0]]),
        .p_o(prod)
    );

    // Buffers are deliberately left out of reset.
    always_ff @(posedge CLK) begin
        if (w_we) w_buf[wi_q[AW-1:0]] <= W_IN;
        if (s_we) s_buf[si_q[AW-1:0]] <= S_IN;
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= ST_IDLE;
            n_q     <= '0;
            wi_q    <= '0;
            si_q    <= '0;
            j_q     <= '0;
            k_q     <= '0;
            p_q     <= '0;
            acc_q   <= '0;
            wout_q  <= '0;
            ready_q <= 1'b0;
            woe_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            n_q     <= n_d;
            wi_q    <= wi_d;
            si_q    <= si_d;
            j_q     <= j_d;
            k_q     <= k_d;
            p_q     <= p_d;
            acc_q   <= acc_d;
            wout_q  <= wout_d;
            ready_q <= ready_d;
            woe_q   <= woe_d;
        end
    end

    // DONE holds until READY has been presented, which gives n = 0 its
    // two-cycle START-to-READY latency.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:    if (START) state_d = (size_clamp == '0) ? ST_DONE : ST_LOAD;
            ST_LOAD:    if (load_done) state_d = ST_COMPUTE;
            ST_COMPUTE: if (k_last) state_d = ST_EMIT;
            ST_EMIT:    state_d = j_last ? ST_DONE : ST_COMPUTE;
            ST_DONE:    if (ready_q) state_d = ST_IDLE;
            default:    state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        n_d   = n_q;
        wi_d  = wi_q;
        si_d  = si_q;
        j_d   = j_q;
        k_d   = k_q;
        p_d   = p_q;
        acc_d = acc_q;
        case (state_q)
            ST_IDLE: if (START) begin
                n_d   = size_clamp;
                wi_d  = '0;
                si_d  = '0;
                j_d   = '0;
                k_d   = '0;
                p_d   = '0;
                acc_d = '0;
            end
            ST_LOAD: begin
                wi_d = wi_nx;
                si_d = si_nx;
                if (load_done) begin
                    acc_d = '0;
                    k_d   = '0;
                    p_d   = j_q;
                end
            end
            ST_COMPUTE: begin
                acc_d = mac_sum;
                k_d   = k_q + ONE_I;
                // Modular index by wrap-around instead of a divider.
                p_d   = (p_q == '0) ? n_m1 : p_q - ONE_I;
            end
            ST_EMIT: if (!j_last) begin
                j_d   = j_q + ONE_I;
                acc_d = '0;
                k_d   = '0;
                p_d   = j_q + ONE_I;
            end
            default: ;
        endcase
    end

    // Outputs are registered on the transition into EMIT/DONE so the strobe
    // lands in the EMIT cycle itself.
    always_comb begin
        ready_d = 1'b0;
        woe_d   = 1'b0;
        wout_d  = wout_q;
        case (state_q)
            ST_COMPUTE: if (k_last) begin
                woe_d  = 1'b1;
                wout_d = mac_sum;
            end
            ST_EMIT: ready_d = j_last;
            ST_DONE: ready_d = !ready_q;
            default: ;
        endcase
    end

    assign READY        = ready_q;
    assign W_OUT_ENABLE = woe_q;
    assign W_OUT        = wout_q;

endmodule

// File: tb/tb_model_convolution_shift.sv
// Scoreboard bench: two instances (integer format and default Q32.32) share
// the load bus; a monitor pops expected outputs and their cycle numbers.
module tb_model_convolution_shift;
    import model_ntm_pkg::*;

    typedef struct {
        logic [63:0] d;
        int          c;
    } exp_t;

    logic CLK = 1'b0, RST = 1'b1, START0 = 1'b0, START32 = 1'b0, WE = 1'b0, SE = 1'b0;
    logic [63:0] SZ = '0, WD = '0, SD = '0;
    logic RDY0, RDY32, WOE0, WOE32;
    logic [63:0] WO0, WO32;

    int tests = 0, fails = 0, cyc = 0;
    int c_first, last_c, start_c;
    exp_t eq0[$], eq32[$];
    int rq0[$], rq32[$];
    logic [63:0] wv[64], sv[64], ev[64];

    always #5 CLK = ~CLK;
    always @(posedge CLK) cyc <= cyc + 1;

    model_convolution_shift #(.DATA_SIZE(64), .FRACTION_SIZE(0), .N(64)) dut0 (
        .CLK(CLK), .RST(RST), .START(START0), .READY(RDY0),
        .W_IN_ENABLE(WE), .S_IN_ENABLE(SE), .W_OUT_ENABLE(WOE0),
        .SIZE_N_IN(SZ), .W_IN(WD), .S_IN(SD), .W_OUT(WO0));

    model_convolution_shift #(.DATA_SIZE(64), .FRACTION_SIZE(32), .N(64)) dut32 (
        .CLK(CLK), .RST(RST), .START(START32), .READY(RDY32),
        .W_IN_ENABLE(WE), .S_IN_ENABLE(SE), .W_OUT_ENABLE(WOE32),
        .SIZE_N_IN(SZ), .W_IN(WD), .S_IN(SD), .W_OUT(WO32));

    task automatic cmp(input string name, input logic [63:0] act, input logic [63:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %h, expected %h", name, act, req);
        end
    endtask

    task automatic chk_strobe(input int sel, input logic [63:0] d);
        exp_t e;
        int sz;
        sz = (sel == 0) ? eq0.size() : eq32.size();
        tests++;
        if (sz == 0) begin
            fails++;
            $display("FAIL strobe%0d: unexpected W_OUT_ENABLE at cycle %0d (W_OUT=%h), expected none", sel, cyc, d);
        end else begin
            if (sel == 0) e = eq0.pop_front();
            else          e = eq32.pop_front();
            if (d !== e.d || cyc != e.c) begin
                fails++;
                $display("FAIL strobe%0d: got %h at cycle %0d, expected %h at cycle %0d", sel, d, cyc, e.d, e.c);
            end
        end
    endtask

    task automatic chk_ready(input int sel);
        int sz, c;
        sz = (sel == 0) ? rq0.size() : rq32.size();
        tests++;
        if (sz == 0) begin
            fails++;
            $display("FAIL ready%0d: unexpected READY at cycle %0d, expected none", sel, cyc);
        end else begin
            if (sel == 0) c = rq0.pop_front();
            else          c = rq32.pop_front();
            if (cyc != c) begin
                fails++;
                $display("FAIL ready%0d: got READY at cycle %0d, expected cycle %0d", sel, cyc, c);
            end
        end
    endtask

    always @(negedge CLK) begin
        if (WOE0)  chk_strobe(0, WO0);
        if (WOE32) chk_strobe(1, WO32);
        if (RDY0)  chk_ready(0);
        if (RDY32) chk_ready(1);
    end

    task automatic step(input logic we, input logic [63:0] wd, input logic se, input logic [63:0] sd);
        WE = we; WD = wd; SE = se; SD = sd;
        last_c = cyc;
        @(negedge CLK);
        WE = 1'b0; SE = 1'b0;
    endtask

    task automatic set4(input logic [63:0] w0, w1, w2, w3, s0, s1, s2, s3, e0, e1, e2, e3);
        wv[0] = w0; wv[1] = w1; wv[2] = w2; wv[3] = w3;
        sv[0] = s0; sv[1] = s1; sv[2] = s2; sv[3] = s3;
        ev[0] = e0; ev[1] = e1; ev[2] = e2; ev[3] = e3;
    endtask

    function automatic int pending(input int sel);
        return (sel == 0) ? eq0.size() + rq0.size() : eq32.size() + rq32.size();
    endfunction

    // mode: 0 simultaneous, 1 w first (+2 extra w), 2 interleaved, 3 s first (+2 extra s)
    task automatic run(input int sel, input logic [63:0] size_in, input int n, input int mode, input bit poke);
        exp_t e;
        int t;
        @(negedge CLK);
        start_c = cyc; SZ = size_in;
        if (sel == 0) START0 = 1'b1; else START32 = 1'b1;
        @(negedge CLK);
        START0 = 1'b0; START32 = 1'b0;
        if (n == 0) begin
            if (sel == 0) rq0.push_back(start_c + 2); else rq32.push_back(start_c + 2);
        end else begin
            case (mode)
                0: for (int i = 0; i < n; i++) step(1'b1, wv[i], 1'b1, sv[i]);
                1: begin
                    for (int i = 0; i < n + 2; i++) step(1'b1, (i < n) ? wv[i] : 64'hDEAD, 1'b0, '0);
                    for (int i = 0; i < n; i++) step(1'b0, '0, 1'b1, sv[i]);
                end
                2: for (int i = 0; i < n; i++) begin
                    step(1'b1, wv[i], 1'b0, '0);
                    step(1'b0, '0, 1'b1, sv[i]);
                end
                default: begin
                    for (int i = 0; i < n + 2; i++) step(1'b0, '0, 1'b1, (i < n) ? sv[i] : 64'hBEEF);
                    for (int i = 0; i < n; i++) step(1'b1, wv[i], 1'b0, '0);
                end
            endcase
            c_first = last_c + 1;
            for (int j = 0; j < n; j++) begin
                e.d = ev[j];
                e.c = c_first + j * (n + 1) + n;
                if (sel == 0) eq0.push_back(e); else eq32.push_back(e);
            end
            if (sel == 0) rq0.push_back(c_first + n * (n + 1));
            else          rq32.push_back(c_first + n * (n + 1));
            if (poke) begin
                @(negedge CLK);
                SZ = 64'd1;
                if (sel == 0) START0 = 1'b1; else START32 = 1'b1;
                @(negedge CLK);
                START0 = 1'b0; START32 = 1'b0;
            end
        end
        t = 0;
        while (pending(sel) != 0 && t < 6000) begin
            @(negedge CLK);
            t++;
        end
        if (t >= 6000) begin
            tests++; fails++;
            $display("FAIL timeout%0d: %0d expected events still pending, expected 0", sel, pending(sel));
            eq0.delete(); eq32.delete(); rq0.delete(); rq32.delete();
        end
    endtask

    initial begin
        repeat (3) @(negedge CLK);
        cmp("reset READY0", {63'd0, RDY0}, '0);
        cmp("reset WOE0", {63'd0, WOE0}, '0);
        cmp("reset W_OUT0", WO0, '0);
        cmp("reset READY32", {63'd0, RDY32}, '0);
        cmp("reset W_OUT32", WO32, '0);
        RST = 1'b0;

        // Shift by one, integer format, all load orderings, START poke in COMPUTE
        set4(1, 2, 3, 4, 0, 1, 0, 0, 4, 1, 2, 3);
        run(0, 4, 4, 0, 1'b0);
        run(0, 4, 4, 1, 1'b0);
        run(0, 4, 4, 2, 1'b0);
        run(0, 4, 4, 3, 1'b1);

        // Signed operands, n=3
        set4(-64'sd1, 64'sd2, -64'sd3, 0, 64'sd2, 0, -64'sd1, 0, -64'sd4, 64'sd7, -64'sd5, 0);
        run(0, 3, 3, 0, 1'b0);

        // n=1 and n=0 boundaries
        set4(5, 0, 0, 0, 3, 0, 0, 0, 15, 0, 0, 0);
        run(0, 1, 1, 0, 1'b0);
        run(0, 0, 0, 0, 1'b0);

        // Identity in Q32.32
        set4(64'h10, 64'h20, 64'h30, 64'h40, FIXED_ONE, 0, 0, 0, 64'h10, 64'h20, 64'h30, 64'h40);
        run(1, 4, 4, 1, 1'b0);

        // Fractional spread
        set4(64'h8000_0000, 64'h8000_0000, 0, 0, 64'h8000_0000, 0, 0, 64'h8000_0000,
             64'h8000_0000, 64'h4000_0000, 0, 64'h4000_0000);
        run(1, 4, 4, 2, 1'b0);

        // Arithmetic (not logical) shift: -1 * 2^-32 stays -1 LSB
        set4(64'hFFFF_FFFF_FFFF_FFFF, 0, 0, 0, 64'd1, 0, 0, 0, 64'hFFFF_FFFF_FFFF_FFFF, 0, 0, 0);
        run(1, 1, 1, 0, 1'b0);

        // Oversized request clamps to 64; delayed-by-one shift
        for (int i = 0; i < 64; i++) begin
            wv[i] = 64'(i + 1);
            sv[i] = (i == 1) ? 64'd1 : 64'd0;
        end
        for (int j = 0; j < 64; j++) ev[j] = wv[(j + 63) % 64];
        run(0, 100, 64, 0, 1'b0);

        // Reset in the middle of COMPUTE on the Q32.32 instance
        set4(64'h10, 64'h20, 64'h30, 64'h40, FIXED_ONE, 0, 0, 0, 64'h10, 64'h20, 64'h30, 64'h40);
        @(negedge CLK);
        SZ = 4; START32 = 1'b1;
        @(negedge CLK);
        START32 = 1'b0;
        for (int i = 0; i < 4; i++) step(1'b1, wv[i], 1'b1, sv[i]);
        @(negedge CLK);
        RST = 1'b1;
        @(negedge CLK);
        RST = 1'b0;
        cmp("rst READY32", {63'd0, RDY32}, '0);
        cmp("rst WOE32", {63'd0, WOE32}, '0);
        cmp("rst W_OUT32", WO32, '0);
        repeat (8) @(negedge CLK);
        cmp("rst quiet WOE32", {63'd0, WOE32}, '0);
        run(1, 4, 4, 0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
